// File: rtl/input_port_vc_unit.sv
// input_port_vc_unit: per-input-port VC FIFOs, VC state (IDLE/VA/ACTIVE), switch request/pop path and on/off flow control
// clk/rst           : rising-edge clock, asynchronous active-low reset
// flit_*_i          : incoming link flit (type, VC, precomputed out port, payload)
// on_off_o          : per-VC permission for the upstream router to send
// va_*              : downstream VC allocation request/port and grant/granted VC
// switch_request_o  : per-VC flit-ready to the switch allocator, with latched out_port_o/downstream_vc_o
// vc_sel_i/valid_sel_i, flit_o : switch grant and the popped {type, downstream_vc, data}
// error_o           : sticky overflow / packet-framing error
module input_port_vc_unit #(
    parameter int VC_NUM      = 2,
    parameter int PORT_NUM    = 5,
    parameter int BUFFER_SIZE = 8,
    parameter int DATA_W      = 32,
    parameter int OFF_MARGIN  = 2,
    localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int PORT_SIZE  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flit_valid_i,
    input  logic [1:0]                            flit_type_i,
    input  logic [VC_SIZE-1:0]                    flit_vc_i,
    input  logic [PORT_SIZE-1:0]                  flit_out_port_i,
    input  logic [DATA_W-1:0]                     flit_data_i,
    output logic [VC_NUM-1:0]                     on_off_o,
    output logic [VC_NUM-1:0]                     va_request_o,
    output logic [VC_NUM-1:0][PORT_SIZE-1:0]      va_port_o,
    input  logic [VC_NUM-1:0]                     va_grant_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]        va_downstream_vc_i,
    output logic [VC_NUM-1:0]                     switch_request_o,
    output logic [VC_NUM-1:0][PORT_SIZE-1:0]      out_port_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]        downstream_vc_o,
    input  logic [VC_SIZE-1:0]                    vc_sel_i,
    input  logic                                  valid_sel_i,
    output logic [2+VC_SIZE+DATA_W-1:0]           flit_o,
    output logic                                  error_o
);
    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 + PORT_SIZE + DATA_W;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VA     = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [ENT_W-1:0]                 mem_q [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]                 wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]                 wr_ptr_d [VC_NUM];
    logic [PTR_W-1:0]                 rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0]                 rd_ptr_d [VC_NUM];
    logic [CNT_W-1:0]                 count_q [VC_NUM];
    logic [CNT_W-1:0]                 count_d [VC_NUM];
    logic [1:0]                       state_q [VC_NUM];
    logic [1:0]                       state_d [VC_NUM];
    logic [VC_NUM-1:0]                on_off_q, on_off_d;
    logic [VC_NUM-1:0][PORT_SIZE-1:0] out_port_q, out_port_d;
    logic [VC_NUM-1:0][VC_SIZE-1:0]   dvc_q, dvc_d;
    logic                             error_q, error_d;
    logic [1:0]                       head_type [VC_NUM];
    logic [PORT_SIZE-1:0]             head_port [VC_NUM];
    logic [DATA_W-1:0]                head_data [VC_NUM];
    logic [VC_NUM-1:0]                wr_hit, push, pop_sw, drop, start;

    for (genvar g = 0; g < VC_NUM; g++) begin : g_head
        assign {head_type[g], head_port[g], head_data[g]} = mem_q[g][rd_ptr_q[g]];
    end

    always_comb begin
        error_d          = error_q;
        flit_o           = '0;
        va_request_o     = '0;
        switch_request_o = '0;
        wr_hit           = '0;
        push             = '0;
        pop_sw           = '0;
        drop             = '0;
        start            = '0;
        on_off_d         = '0;
        out_port_d       = out_port_q;
        dvc_d            = dvc_q;
        for (int v = 0; v < VC_NUM; v++) begin
            // HEAD(0)/HEADTAIL(3) open a packet; BODY(1)/TAIL(2) at an IDLE head are orphans
            start[v]  = state_q[v] == IDLE && count_q[v] != '0 && head_type[v][1] == head_type[v][0];
            drop[v]   = state_q[v] == IDLE && count_q[v] != '0 && head_type[v][1] != head_type[v][0];
            pop_sw[v] = valid_sel_i && vc_sel_i == VC_SIZE'(v) && state_q[v] == ACTIVE && count_q[v] != '0;
            wr_hit[v] = flit_valid_i && flit_vc_i == VC_SIZE'(v);
            push[v]   = wr_hit[v] && count_q[v] != CNT_W'(BUFFER_SIZE);
            wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(push[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop_sw[v] | drop[v]);
            count_d[v]  = count_q[v] + CNT_W'(push[v]) - CNT_W'(pop_sw[v] | drop[v]);
            on_off_d[v] = (BUFFER_SIZE - int'(count_d[v])) > OFF_MARGIN;
            error_d     = error_d | (wr_hit[v] & ~push[v]) | drop[v];
            state_d[v]  = state_q[v] == IDLE ? (start[v] ? VA : IDLE) :
                          state_q[v] == VA   ? (va_grant_i[v] ? ACTIVE : VA) :
                          (pop_sw[v] && head_type[v][1]) ? IDLE : ACTIVE;
            out_port_d[v] = start[v] ? head_port[v] : out_port_q[v];
            dvc_d[v]      = (state_q[v] == VA && va_grant_i[v]) ? va_downstream_vc_i[v] : dvc_q[v];
            va_request_o[v]     = state_q[v] == VA;
            switch_request_o[v] = state_q[v] == ACTIVE && count_q[v] != '0;
            // at most one VC matches vc_sel_i, so this acts as the output mux
            if (pop_sw[v]) flit_o = {head_type[v], dvc_q[v], head_data[v]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                state_q[v]  <= IDLE;
            end
            on_off_q   <= '1;
            out_port_q <= '0;
            dvc_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
                state_q[v]  <= state_d[v];
            end
            on_off_q   <= on_off_d;
            out_port_q <= out_port_d;
            dvc_q      <= dvc_d;
            error_q    <= error_d;
        end
    end

    // payload storage needs no reset: pointers and counts define validity
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++)
            if (push[v]) mem_q[v][wr_ptr_q[v]] <= {flit_type_i, flit_out_port_i, flit_data_i};
    end

    assign on_off_o        = on_off_q;
    assign va_port_o       = out_port_q;
    assign out_port_o      = out_port_q;
    assign downstream_vc_o = dvc_q;
    assign error_o         = error_q;
endmodule

// File: tb/tb_input_port_vc_unit.sv
// tb_input_port_vc_unit: directed self-checking bench for input_port_vc_unit
module tb_input_port_vc_unit;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flit_valid;
    logic [1:0]      flit_type;
    logic            flit_vc;
    logic [2:0]      flit_port;
    logic [31:0]     flit_data;
    logic [1:0]      on_off;
    logic [1:0]      va_req;
    logic [1:0][2:0] va_port;
    logic [1:0]      va_grant;
    logic [1:0]      va_dvc;
    logic [1:0]      sw_req;
    logic [1:0][2:0] out_port;
    logic [1:0]      dvc;
    logic            vc_sel;
    logic            valid_sel;
    logic [34:0]     flit_out;
    logic            err;
    int              errors = 0;
    int              checks = 0;
    int              n;
    logic [1:0]      t2_types [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic            t6_sel   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [34:0]     t6_exp   [5] = '{{2'd0, 1'b1, 32'h600}, {2'd0, 1'b0, 32'h610},
                                      {2'd1, 1'b1, 32'h601}, {2'd2, 1'b0, 32'h611},
                                      {2'd2, 1'b1, 32'h602}};

    always #5 clk = ~clk;

    input_port_vc_unit dut (
        .clk(clk), .rst(rst),
        .flit_valid_i(flit_valid), .flit_type_i(flit_type), .flit_vc_i(flit_vc),
        .flit_out_port_i(flit_port), .flit_data_i(flit_data),
        .on_off_o(on_off), .va_request_o(va_req), .va_port_o(va_port),
        .va_grant_i(va_grant), .va_downstream_vc_i(va_dvc),
        .switch_request_o(sw_req), .out_port_o(out_port), .downstream_vc_o(dvc),
        .vc_sel_i(vc_sel), .valid_sel_i(valid_sel), .flit_o(flit_out), .error_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flit_valid = 1'b0; flit_type = 2'd0; flit_vc = 1'b0; flit_port = 3'd0; flit_data = 32'd0;
        va_grant = 2'b00; va_dvc = 2'b00; vc_sel = 1'b0; valid_sel = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic vc, input logic [2:0] p, input logic [31:0] d);
        flit_valid = 1'b1; flit_type = t; flit_vc = vc; flit_port = p; flit_data = d;
        step();
        flit_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        check("rst_on_off",   64'(on_off),   64'(2'b11));
        check("rst_va_req",   64'(va_req),   64'(2'b00));
        check("rst_sw_req",   64'(sw_req),   64'(2'b00));
        check("rst_err",      64'(err),      64'(1'b0));
        check("rst_out_port", 64'(out_port), 64'(6'd0));
        check("rst_va_port",  64'(va_port),  64'(6'd0));
        check("rst_dvc",      64'(dvc),      64'(2'b00));
        check("rst_flit",     64'(flit_out), 64'(35'd0));
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input logic vc, output int cnt);
        cnt = 0;
        valid_sel = 1'b1; vc_sel = vc;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (!sw_req[vc]) break;
            cnt++;
            step();
        end
        valid_sel = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        // single HEADTAIL on VC0
        send(2'd3, 1'b0, 3'd3, 32'hA5A5_0001);
        check("t1_va_req_latency", 64'(va_req), 64'(2'b00));
        step();
        check("t1_va_req", 64'(va_req), 64'(2'b01));
        check("t1_va_port", 64'(va_port[0]), 64'(3'd3));
        va_grant = 2'b01; va_dvc = 2'b01;
        step();
        va_grant = 2'b00;
        check("t1_sw_req", 64'(sw_req), 64'(2'b01));
        check("t1_dvc", 64'(dvc[0]), 64'(1'b1));
        check("t1_out_port", 64'(out_port[0]), 64'(3'd3));
        valid_sel = 1'b1; vc_sel = 1'b0;
        #1;
        check("t1_flit", 64'(flit_out), 64'({2'd3, 1'b1, 32'hA5A5_0001}));
        step();
        valid_sel = 1'b0;
        check("t1_sw_req_done", 64'(sw_req), 64'(2'b00));
        check("t1_va_req_done", 64'(va_req), 64'(2'b00));
        valid_sel = 1'b1; vc_sel = 1'b1;
        #1;
        check("t1_grant_idle_vc", 64'(flit_out), 64'(35'd0));
        valid_sel = 1'b0;
        // 4-flit packet on VC1, popped every cycle
        send(2'd0, 1'b1, 3'd2, 32'h200);
        send(2'd1, 1'b1, 3'd7, 32'h201);
        send(2'd1, 1'b1, 3'd7, 32'h202);
        send(2'd2, 1'b1, 3'd7, 32'h203);
        check("t2_on_off", 64'(on_off), 64'(2'b11));
        check("t2_va_req", 64'(va_req), 64'(2'b10));
        check("t2_va_port", 64'(va_port[1]), 64'(3'd2));
        va_grant = 2'b10; va_dvc = 2'b10;
        step();
        va_grant = 2'b00;
        check("t2_sw_req", 64'(sw_req), 64'(2'b10));
        valid_sel = 1'b1; vc_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_flit%0d", i), 64'(flit_out), 64'({t2_types[i], 1'b1, 32'h200 + 32'(i)}));
            check($sformatf("t2_on%0d", i), 64'(on_off[1]), 64'(1'b1));
            step();
        end
        valid_sel = 1'b0;
        check("t2_sw_req_done", 64'(sw_req), 64'(2'b00));
        check("t2_va_req_done", 64'(va_req), 64'(2'b00));
        // fill VC0 with no grants, then overflow
        do_reset();
        send(2'd0, 1'b0, 3'd1, 32'h300);
        for (int i = 1; i < 5; i++) send(2'd1, 1'b0, 3'd0, 32'h300 + 32'(i));
        check("t3_on5", 64'(on_off), 64'(2'b11));
        send(2'd1, 1'b0, 3'd0, 32'h305);
        check("t3_off6", 64'(on_off), 64'(2'b10));
        send(2'd1, 1'b0, 3'd0, 32'h306);
        send(2'd1, 1'b0, 3'd0, 32'h307);
        check("t3_err8", 64'(err), 64'(1'b0));
        check("t3_off8", 64'(on_off), 64'(2'b10));
        send(2'd1, 1'b0, 3'd0, 32'h308);
        check("t3_err9", 64'(err), 64'(1'b1));
        check("t3_va_req", 64'(va_req), 64'(2'b01));
        va_grant = 2'b01; va_dvc = 2'b00;
        step();
        va_grant = 2'b00;
        drain(1'b0, n);
        check("t3_count", 64'(n), 64'(8));
        check("t3_on_after", 64'(on_off), 64'(2'b11));
        check("t3_err_sticky", 64'(err), 64'(1'b1));
        // simultaneous push and pop at count 5
        do_reset();
        send(2'd0, 1'b0, 3'd5, 32'h400);
        for (int i = 1; i < 5; i++) send(2'd1, 1'b0, 3'd0, 32'h400 + 32'(i));
        va_grant = 2'b01; va_dvc = 2'b01;
        step();
        va_grant = 2'b00;
        check("t4_on_pre", 64'(on_off), 64'(2'b11));
        flit_valid = 1'b1; flit_type = 2'd1; flit_vc = 1'b0; flit_data = 32'h405;
        valid_sel = 1'b1; vc_sel = 1'b0;
        #1;
        check("t4_flit", 64'(flit_out), 64'({2'd0, 1'b1, 32'h400}));
        step();
        flit_valid = 1'b0; valid_sel = 1'b0;
        check("t4_on_post", 64'(on_off), 64'(2'b11));
        check("t4_err", 64'(err), 64'(1'b0));
        drain(1'b0, n);
        check("t4_count", 64'(n), 64'(5));
        // orphan BODY on idle VC1
        do_reset();
        send(2'd1, 1'b1, 3'd0, 32'h500);
        check("t5_err_pre", 64'(err), 64'(1'b0));
        step();
        check("t5_err", 64'(err), 64'(1'b1));
        check("t5_va_req", 64'(va_req), 64'(2'b00));
        step();
        check("t5_va_req2", 64'(va_req), 64'(2'b00));
        check("t5_sw_req", 64'(sw_req), 64'(2'b00));
        // interleaved packets, then reset mid-packet
        do_reset();
        send(2'd0, 1'b0, 3'd1, 32'h600);
        send(2'd0, 1'b1, 3'd4, 32'h610);
        send(2'd1, 1'b0, 3'd0, 32'h601);
        send(2'd2, 1'b1, 3'd0, 32'h611);
        send(2'd2, 1'b0, 3'd0, 32'h602);
        check("t6_va_req", 64'(va_req), 64'(2'b11));
        check("t6_va_port", 64'(va_port), 64'({3'd4, 3'd1}));
        va_grant = 2'b11; va_dvc = 2'b01;
        step();
        va_grant = 2'b00;
        check("t6_dvc", 64'(dvc), 64'(2'b01));
        valid_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vc_sel = t6_sel[i];
            #1;
            check($sformatf("t6_flit%0d", i), 64'(flit_out), 64'(t6_exp[i]));
            step();
        end
        valid_sel = 1'b0;
        check("t6_sw_req_done", 64'(sw_req), 64'(2'b00));
        check("t6_va_req_done", 64'(va_req), 64'(2'b00));
        send(2'd0, 1'b0, 3'd6, 32'h700);
        send(2'd1, 1'b0, 3'd0, 32'h701);
        step();
        check("t6_mid_va_req", 64'(va_req), 64'(2'b01));
        do_reset();
        step();
        step();
        check("t6_post_va_req", 64'(va_req), 64'(2'b00));
        check("t6_post_sw_req", 64'(sw_req), 64'(2'b00));
        check("t6_post_on_off", 64'(on_off), 64'(2'b11));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
